instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Upstream control stage for the 4-bit register-file/ALU datapath. It holds a small writable program memory of 12-bit instructions and steps through them with a program counter. It decodes each instruction into the datapath control fields (Ext_Data, Addr_Src1/2, Addr_Dest, isExternal, ALUSel). It also issues a one-cycle write strobe that replaces the manual push-button write. Stepping is driven by an already-debounced one-cycle pulse.

Parameters:
INSTR_W, 12, instruction width in bits (fixed format below).
DEPTH, 8, program memory entries; PC width = $clog2(DEPTH).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
step  input  1  one-cycle pulse (debounced); starts one instruction
prog_we  input  1  program memory write enable
prog_addr  input  $clog2(DEPTH)  program write address
prog_data  input  INSTR_W  program write data
Ext_Data  output  4  immediate to datapath
Addr_Src1  output  3  register-file read address 1
Addr_Src2  output  3  register-file read address 2
Addr_Dest  output  3  register-file write address
isExternal  output  1  1 = write Ext_Data, 0 = write ALU result
ALUSel  output  2  ALU operation
wr_pulse  output  1  one-cycle register-file write strobe
pc  output  $clog2(DEPTH)  current program counter
halted  output  1  HALT executed

Behaviour:
- Instruction format:
  - [11:9] opcode; [8:6] dest; [5:3] src1; [2:0] src2; [3:0] imm for LDI.
  - Opcodes 000 ADD, 001 SUB, 010 AND, 011 OR: isExternal=0, ALUSel=opcode[1:0].
  - 100 LDI: isExternal=1, Ext_Data=imm; src fields ignored, Addr_Src1/2 driven 0.
  - 111 HALT. 101/110 NOP.
- FSM states IDLE, FETCH, DECODE, EXEC, HALT. Reset state is IDLE.
- IDLE + step → FETCH. Program memory read is registered; data is valid after 1 cycle.
- FETCH → DECODE. Instruction fields are registered onto the output ports.
- DECODE → EXEC.
  - ALU/LDI: wr_pulse=1 for exactly this cycle.
  - NOP/HALT: wr_pulse=0.
- EXEC → IDLE. PC increments; (DEPTH-1) wraps to 0.
- EXEC of HALT → HALT state instead. halted=1 and PC is not incremented.
- HALT is left only by reset.
- Latency: step to wr_pulse = 3 cycles. Control outputs are stable from DECODE+1 until the next DECODE.
- step outside IDLE is ignored (not queued).
- prog_we is accepted only in IDLE or HALT; it is ignored otherwise. Writing the address equal to pc takes effect on the next fetch.
- Reset, asserted at any time including mid-instruction: state=IDLE, pc=0, all outputs 0, halted=0, wr_pulse=0 immediately. Program memory contents are retained through reset and initialise to all zeros at configuration.

Optional Feature:
AUTO_RUN_EN:
- Defined: adds input run (1 bit) and parameter RUN_DIV (default 25_000_000).
- While run=1 and in IDLE, a prescaler counts RUN_DIV cycles, then self-issues a step.
- The counter clears on reset, when run=0, or on leaving IDLE.
- External step still works.
- Not defined: no run port, no prescaler; stepping is only via step.

Decomposition:
- Package instr_seq_pkg: opcode enum (OP_ADD..OP_HALT), state enum, field bit-position localparams, ALUSel encodings shared with the ALU.
- Sub-module prog_mem: DEPTH×INSTR_W writable memory, synchronous write, registered read.

Test Plan:
- Reset then prog 0=LDI r1,5 (0x845), step → wr_pulse exactly 3 cycles later, Addr_Dest=1, isExternal=1, Ext_Data=5, pc goes 0→1.
- Program LDI r1,5; LDI r2,3; SUB r3,r1,r2 (0x2CA); 3 steps → third EXEC gives ALUSel=01, Src1=1, Src2=2, Dest=3, isExternal=0, one wr_pulse per step.
- step pulses during FETCH/DECODE/EXEC → ignored, exactly one wr_pulse, pc advances by 1 only.
- Program all 8 entries as NOP, 8 steps → no wr_pulse, pc wraps 7→0.
- HALT (0xE00) at pc=2 → halted=1, pc stays 2, further steps give no output change; reset → pc=0, halted=0, memory intact.
- Assert reset during DECODE → outputs 0 same cycle; prog_we during EXEC ignored (readback unchanged); with AUTO_RUN_EN, RUN_DIV=4, run=1 → wr_pulse every 4+4 cycles.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: instruction field positions,
// opcode and FSM state encodings, and the ALUSel codes understood by the ALU.
package instr_seq_pkg;

  localparam int OPC_MSB  = 11;
  localparam int OPC_LSB  = 9;
  localparam int DST_MSB  = 8;
  localparam int DST_LSB  = 6;
  localparam int SRC1_MSB = 5;
  localparam int SRC1_LSB = 3;
  localparam int SRC2_MSB = 2;
  localparam int SRC2_LSB = 0;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_LDI  = 3'b100,
    OP_NOP5 = 3'b101,
    OP_NOP6 = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ALU ops and LDI are the only instructions that write the register file.
  function automatic logic op_writes(input opcode_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_sel(input opcode_e op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Writable program store: synchronous write, registered read (data valid one
// cycle after the address). Contents are not touched by reset.
module prog_mem #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // Power-up contents are all zeros (FPGA configuration image).
  logic [W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program-counter sequencer driving the 4-bit register-file/ALU datapath.
// Optional AUTO_RUN_EN adds a run input and a RUN_DIV prescaler that self-steps.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int INSTR_W = 12,
  parameter int DEPTH   = 8,
`ifdef AUTO_RUN_EN
  parameter int RUN_DIV = 25_000_000,
`endif
  localparam int PC_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
`ifdef AUTO_RUN_EN
  input  logic               run,
`endif
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         Ext_Data,
  output logic [2:0]         Addr_Src1,
  output logic [2:0]         Addr_Src2,
  output logic [2:0]         Addr_Dest,
  output logic               isExternal,
  output logic [1:0]         ALUSel,
  output logic               wr_pulse,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(DEPTH - 1);

  state_e             state, next_state;
  opcode_e            op_q;
  opcode_e            cur_op;
  logic [INSTR_W-1:0] instr;
  logic               step_any;
  logic               mem_we;

  assign mem_we = prog_we && (state == S_IDLE || state == S_HALT);

  prog_mem #(.W(INSTR_W), .DEPTH(DEPTH)) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (instr)
  );

`ifdef AUTO_RUN_EN
  localparam int CNT_W = $clog2(RUN_DIV + 1);
  logic [CNT_W-1:0] run_cnt;
  logic             auto_step;

  // Idle for RUN_DIV counted cycles, then issue the step on the following one.
  assign auto_step = run && (state == S_IDLE) && (run_cnt == CNT_W'(RUN_DIV));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    run_cnt <= '0;
    else if (!run || state != S_IDLE || auto_step) run_cnt <= '0;
    else                                          run_cnt <= run_cnt + 1'b1;
  end

  assign step_any = step || auto_step;
`else
  assign step_any = step;
`endif

  assign cur_op = opcode_e'(instr[OPC_MSB:OPC_LSB]);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (step_any) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC:   next_state = (op_q == OP_HALT) ? S_HALT : S_IDLE;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Fields are captured as FETCH ends, so they hold from DECODE to the next DECODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_ADD;
      Ext_Data   <= '0;
      Addr_Src1  <= '0;
      Addr_Src2  <= '0;
      Addr_Dest  <= '0;
      isExternal <= 1'b0;
      ALUSel     <= '0;
      wr_pulse   <= 1'b0;
      pc         <= '0;
    end else begin
      wr_pulse <= (state == S_DECODE) && op_writes(op_q);
      if (state == S_FETCH) begin
        op_q       <= cur_op;
        Addr_Dest  <= instr[DST_MSB:DST_LSB];
        isExternal <= (cur_op == OP_LDI);
        Ext_Data   <= (cur_op == OP_LDI) ? instr[IMM_MSB:IMM_LSB] : 4'd0;
        Addr_Src1  <= (cur_op == OP_LDI) ? 3'd0 : instr[SRC1_MSB:SRC1_LSB];
        Addr_Src2  <= (cur_op == OP_LDI) ? 3'd0 : instr[SRC2_MSB:SRC2_LSB];
        ALUSel     <= alu_sel(cur_op);
      end
      if (state == S_EXEC && op_q != OP_HALT)
        pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (default build, AUTO_RUN_EN undefined).
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic [3:0]  Ext_Data;
  logic [2:0]  Addr_Src1, Addr_Src2, Addr_Dest;
  logic        isExternal;
  logic [1:0]  ALUSel;
  logic        wr_pulse;
  logic [2:0]  pc;
  logic        halted;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .Ext_Data   (Ext_Data),
    .Addr_Src1  (Addr_Src1),
    .Addr_Src2  (Addr_Src2),
    .Addr_Dest  (Addr_Dest),
    .isExternal (isExternal),
    .ALUSel     (ALUSel),
    .wr_pulse   (wr_pulse),
    .pc         (pc),
    .halted     (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [2:0] addr, input logic [11:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One step, optionally re-pulsing step through FETCH/DECODE/EXEC; six cycles
  // cover the whole instruction. first_at counts cycles from the step cycle.
  task automatic run_step(input bit spam, output int pulses, output int first_at);
    pulses   = 0;
    first_at = -1;
    step     = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      step = spam && (i <= 3);
      if (wr_pulse) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, f, total;

    // Reset state
    tick();
    tick();
    check("rst_pc", 16'(pc), 16'd0);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_wr_pulse", 16'(wr_pulse), 16'd0);
    check("rst_ext", 16'(Ext_Data), 16'd0);
    check("rst_dest", 16'(Addr_Dest), 16'd0);
    reset = 1'b0;
    tick();

    // LDI r1,5 ; LDI r2,3 ; SUB r3,r1,r2 ; OR r4,r5,r6
    prog(3'd0, 12'h845);
    prog(3'd1, 12'h883);
    prog(3'd2, 12'h2CA);
    prog(3'd3, 12'h72E);

    run_step(1'b0, p, f);
    check("ldi1_pulses", 16'(p), 16'd1);
    check("ldi1_latency", 16'(f), 16'd3);
    check("ldi1_dest", 16'(Addr_Dest), 16'd1);
    check("ldi1_isext", 16'(isExternal), 16'd1);
    check("ldi1_ext", 16'(Ext_Data), 16'd5);
    check("ldi1_src1", 16'(Addr_Src1), 16'd0);
    check("ldi1_pc", 16'(pc), 16'd1);

    run_step(1'b0, p, f);
    check("ldi2_pulses", 16'(p), 16'd1);
    check("ldi2_dest", 16'(Addr_Dest), 16'd2);
    check("ldi2_ext", 16'(Ext_Data), 16'd3);

    run_step(1'b0, p, f);
    check("sub_pulses", 16'(p), 16'd1);
    check("sub_alusel", 16'(ALUSel), 16'd1);
    check("sub_src1", 16'(Addr_Src1), 16'd1);
    check("sub_src2", 16'(Addr_Src2), 16'd2);
    check("sub_dest", 16'(Addr_Dest), 16'd3);
    check("sub_isext", 16'(isExternal), 16'd0);
    check("sub_pc", 16'(pc), 16'd3);

    // Extra step pulses while busy must be ignored
    run_step(1'b1, p, f);
    check("spam_pulses", 16'(p), 16'd1);
    check("spam_pc", 16'(pc), 16'd4);
    check("or_alusel", 16'(ALUSel), 16'd3);
    check("or_src1", 16'(Addr_Src1), 16'd5);
    check("or_src2", 16'(Addr_Src2), 16'd6);
    check("or_dest", 16'(Addr_Dest), 16'd4);

    // All-NOP program: no writes, pc wraps 7 -> 0
    do_reset();
    for (int a = 0; a < 8; a++) prog(3'(a), (a % 2 == 0) ? 12'hA00 : 12'hC00);
    total = 0;
    for (int k = 1; k <= 8; k++) begin
      run_step(1'b0, p, f);
      total += p;
      if (k == 7) check("nop_pc7", 16'(pc), 16'd7);
    end
    check("nop_pulses", 16'(total), 16'd0);
    check("nop_wrap", 16'(pc), 16'd0);

    // HALT at pc=2
    do_reset();
    prog(3'd0, 12'h849);
    prog(3'd1, 12'hC00);
    prog(3'd2, 12'hE00);
    run_step(1'b0, p, f);
    check("h_ldi_pulses", 16'(p), 16'd1);
    run_step(1'b0, p, f);
    check("h_nop_pulses", 16'(p), 16'd0);
    run_step(1'b0, p, f);
    check("halt_pulses", 16'(p), 16'd0);
    check("halt_flag", 16'(halted), 16'd1);
    check("halt_pc", 16'(pc), 16'd2);
    run_step(1'b0, p, f);
    check("halt_step_pulses", 16'(p), 16'd0);
    check("halt_step_pc", 16'(pc), 16'd2);
    check("halt_step_flag", 16'(halted), 16'd1);
    do_reset();
    check("unhalt_pc", 16'(pc), 16'd0);
    check("unhalt_flag", 16'(halted), 16'd0);
    run_step(1'b0, p, f);
    check("retain_pulses", 16'(p), 16'd1);
    check("retain_ext", 16'(Ext_Data), 16'd9);
    check("retain_dest", 16'(Addr_Dest), 16'd1);

    // Reset asserted during DECODE clears outputs without waiting for a clock
    do_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("dec_ext", 16'(Ext_Data), 16'd9);
    check("dec_wr_pulse", 16'(wr_pulse), 16'd0);
    reset = 1'b1;
    #1;
    check("rstdec_ext", 16'(Ext_Data), 16'd0);
    check("rstdec_isext", 16'(isExternal), 16'd0);
    check("rstdec_dest", 16'(Addr_Dest), 16'd0);
    tick();
    check("rstdec_wr_pulse", 16'(wr_pulse), 16'd0);
    check("rstdec_pc", 16'(pc), 16'd0);
    reset = 1'b0;

    // prog_we during EXEC is ignored
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("exec_wr_pulse", 16'(wr_pulse), 16'd1);
    prog_we   = 1'b1;
    prog_addr = 3'd0;
    prog_data = 12'h84F;
    tick();
    prog_we = 1'b0;
    check("exec_pc", 16'(pc), 16'd1);
    do_reset();
    run_step(1'b0, p, f);
    check("exec_we_ignored", 16'(Ext_Data), 16'd9);

    // prog_we in IDLE is taken and used on the next fetch of that address
    do_reset();
    prog(3'd0, 12'h84F);
    run_step(1'b0, p, f);
    check("idle_we_ext", 16'(Ext_Data), 16'd15);
    check("idle_we_pc", 16'(pc), 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
